// File: rtl/im_loader_pkg.sv
// Shared types and widths for the instruction-memory loader.
package im_loader_pkg;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 16;

    typedef enum logic [3:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA_LO,
        DATA_HI,
        WRITE,
        CHK,
        DONE,
        ERR
    } state_t;

    function automatic logic accepts_byte(input state_t s);
        return s inside {LEN_LO, LEN_HI, DATA_LO, DATA_HI, CHK};
    endfunction

    function automatic logic is_active(input state_t s);
        return !(s inside {IDLE, DONE, ERR});
    endfunction

endpackage

// File: rtl/im_loader.sv
// Byte-stream loader that writes a length-prefixed word image into instruction memory.
// Define IM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte per session.
module im_loader
    import im_loader_pkg::*;
#(
    parameter logic [WORD_W-1:0] BASE_ADDR = 16'h0000
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Start,
    input  logic              RxValid,
    input  logic [BYTE_W-1:0] RxData,
    output logic              RxReady,
    output logic              ImWrite,
    output logic [WORD_W-1:0] ImWriteAddr,
    output logic [WORD_W-1:0] ImWriteData,
    output logic              Loading,
    output logic              Done,
    output logic              Error
);

`ifdef IM_LOADER_CHECKSUM_EN
    localparam state_t END_STATE = CHK;
`else
    localparam state_t END_STATE = DONE;
`endif

    state_t            state;
    state_t            next_state;
    logic [WORD_W-1:0] count;
    logic [WORD_W-1:0] addr;
    logic [BYTE_W-1:0] lo_byte;
    logic              accept;

`ifdef IM_LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0] csum;
`else
    assign Error = 1'b0;
`endif

    // RxReady is registered from the state it describes, so this is the true handshake.
    assign accept = RxValid && RxReady;

    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE, ERR: if (Start) next_state = LEN_LO;
            LEN_LO:  if (accept) next_state = LEN_HI;
            LEN_HI:  if (accept) next_state = ({RxData, count[BYTE_W-1:0]} == '0) ? END_STATE : DATA_LO;
            DATA_LO: if (accept) next_state = DATA_HI;
            DATA_HI: if (accept) next_state = WRITE;
            WRITE:   next_state = (count == WORD_W'(1)) ? END_STATE : DATA_LO;
`ifdef IM_LOADER_CHECKSUM_EN
            CHK:     if (accept) next_state = (RxData == csum) ? DONE : ERR;
`endif
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state       <= IDLE;
            RxReady     <= 1'b0;
            Loading     <= 1'b0;
            Done        <= 1'b0;
            ImWrite     <= 1'b0;
            ImWriteAddr <= BASE_ADDR;
            ImWriteData <= '0;
            count       <= '0;
            addr        <= BASE_ADDR;
            lo_byte     <= '0;
`ifdef IM_LOADER_CHECKSUM_EN
            Error       <= 1'b0;
            csum        <= '0;
`endif
        end else begin
            state   <= next_state;
            RxReady <= accepts_byte(next_state);
            Loading <= is_active(next_state);
            ImWrite <= (next_state == WRITE);
            Done    <= (next_state == DONE);
`ifdef IM_LOADER_CHECKSUM_EN
            Error   <= (next_state == ERR);
`endif

            case (state)
                IDLE, DONE, ERR: begin
                    if (Start) begin
                        addr  <= BASE_ADDR;
                        count <= '0;
                    end
                end
                LEN_LO:  if (accept) count[BYTE_W-1:0] <= RxData;
                LEN_HI:  if (accept) count[WORD_W-1:BYTE_W] <= RxData;
                DATA_LO: if (accept) lo_byte <= RxData;
                // Address/data only move here, keeping them stable around each strobe.
                DATA_HI: begin
                    if (accept) begin
                        ImWriteData <= {RxData, lo_byte};
                        ImWriteAddr <= addr;
                    end
                end
                WRITE: begin
                    addr  <= addr + WORD_W'(1);
                    count <= count - WORD_W'(1);
                end
                default: ;
            endcase

`ifdef IM_LOADER_CHECKSUM_EN
            if (!is_active(state) && Start)
                csum <= '0;
            else if (accept && state != CHK)
                csum <= csum ^ RxData;
`endif
        end
    end

endmodule
